// File: rtl/sram_march_bist.sv
// ---------------------------------------------------------------------------
// sram_march_bist
//   March C- built-in self-test engine for a single SRAM macro port.
//   The engine drives the macro's write-enable, mask, address and data, and
//   checks the macro's registered read data one cycle after each read.
//
//   Algorithm (up = address 0..N-1, down = N-1..0):
//     M0 up w0 | M1 up r0,w1 | M2 up r1,w0 | M3 down r0,w1 | M4 down r1,w0
//     | M5 down r0
//   Background "0" is PATTERN and background "1" is ~PATTERN.
//
//   Ports
//     clk, rst         clock, asynchronous active-high reset
//     start            begin a run (honoured only in IDLE or DONE)
//     busy             run in progress
//     done             run complete, held until the next start or rst
//     pass             valid while done: no mismatches were seen
//     err_count        saturating count of mismatching reads
//     first_fail_addr  address of the first mismatch of the run
//     first_fail_elem  march element (0..5) of the first mismatch of the run
//     sram_we/wmask/addr/din  registered command outputs to the macro
//     sram_dout        registered read data from the macro
//
//   Handshake: there is none on the macro side. Every cycle in which busy is
//   high and the state is an element state carries exactly one operation;
//   the macro captures it at the edge ending that cycle and returns read data
//   in the following cycle.
// ---------------------------------------------------------------------------
module sram_march_bist #(
   parameter int DATA_WIDTH    = 64,
   parameter int ADDR_WIDTH    = 9,
   parameter int WMASK_WIDTH   = 8,
   parameter logic [DATA_WIDTH-1:0] PATTERN = {(DATA_WIDTH/2){2'b01}},
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [ERR_CNT_WIDTH-1:0] err_count,
   output logic [ADDR_WIDTH-1:0]    first_fail_addr,
   output logic [2:0]               first_fail_elem,
   output logic                     sram_we,
   output logic [WMASK_WIDTH-1:0]   sram_wmask,
   output logic [ADDR_WIDTH-1:0]    sram_addr,
   output logic [DATA_WIDTH-1:0]    sram_din,
   input  logic [DATA_WIDTH-1:0]    sram_dout
);

   localparam logic [ADDR_WIDTH-1:0]    ADDR_MAX = '1;
   localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX  = '1;

   // FLUSH is the single cycle after the last M5 read, spent waiting for
   // that read's compare before DONE is entered.
   typedef enum logic [3:0] {
      S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_FLUSH, S_DONE
   } state_t;

   // state/addr/phase describe the operation currently presented on sram_*.
   // phase 0 is the read (or the only op) of an address, phase 1 the write.
   state_t                  state, state_nx;
   logic [ADDR_WIDTH-1:0]   addr, addr_nx;
   logic                    phase, phase_nx;
   logic                    clear_nx;

   logic                    op_we_nx;
   logic                    op_active_nx;
   logic [DATA_WIDTH-1:0]   op_din_nx;

   logic                    cur_rd;
   logic [DATA_WIDTH-1:0]   cur_exp;
   logic [2:0]              cur_elem;

   // Compare pipeline stage: describes the read issued in the previous cycle.
   logic                    cmp_valid;
   logic [ADDR_WIDTH-1:0]   cmp_addr;
   logic [2:0]              cmp_elem;
   logic [DATA_WIDTH-1:0]   cmp_exp;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         addr  <= '0;
         phase <= 1'b0;
      end else begin
         state <= state_nx;
         addr  <= addr_nx;
         phase <= phase_nx;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic: walk addresses within an element, hand over to the
   // next element at the last address without an idle cycle.
   // ------------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      addr_nx  = addr;
      phase_nx = phase;
      clear_nx = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_nx = S_M0;
               addr_nx  = '0;
               phase_nx = 1'b0;
               clear_nx = 1'b1;
            end
         end
         S_M0: begin
            phase_nx = 1'b0;
            if (addr == ADDR_MAX) begin
               state_nx = S_M1;
               addr_nx  = '0;
            end else begin
               addr_nx = addr + 1'b1;
            end
         end
         S_M1, S_M2: begin
            if (!phase) begin
               phase_nx = 1'b1;
            end else begin
               phase_nx = 1'b0;
               if (addr == ADDR_MAX) begin
                  // M2 hands over to the first down element, which starts
                  // at the top address.
                  state_nx = (state == S_M1) ? S_M2 : S_M3;
                  addr_nx  = (state == S_M1) ? '0 : ADDR_MAX;
               end else begin
                  addr_nx = addr + 1'b1;
               end
            end
         end
         S_M3, S_M4: begin
            if (!phase) begin
               phase_nx = 1'b1;
            end else begin
               phase_nx = 1'b0;
               if (addr == '0) begin
                  state_nx = (state == S_M3) ? S_M4 : S_M5;
                  addr_nx  = ADDR_MAX;
               end else begin
                  addr_nx = addr - 1'b1;
               end
            end
         end
         S_M5: begin
            phase_nx = 1'b0;
            if (addr == '0) begin
               state_nx = S_FLUSH;
            end else begin
               addr_nx = addr - 1'b1;
            end
         end
         S_FLUSH: begin
            state_nx = S_DONE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Decode of the operation about to be presented (registered into sram_*).
   // ------------------------------------------------------------------------
   always_comb begin
      op_we_nx     = 1'b0;
      op_din_nx    = sram_din;
      op_active_nx = 1'b0;
      case (state_nx)
         S_M0: begin
            op_active_nx = 1'b1;
            op_we_nx     = 1'b1;
            op_din_nx    = PATTERN;
         end
         S_M1, S_M3: begin
            op_active_nx = 1'b1;
            op_we_nx     = phase_nx;
            if (phase_nx) op_din_nx = ~PATTERN;
         end
         S_M2, S_M4: begin
            op_active_nx = 1'b1;
            op_we_nx     = phase_nx;
            if (phase_nx) op_din_nx = PATTERN;
         end
         S_M5: begin
            op_active_nx = 1'b1;
         end
         default: begin
            op_active_nx = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Decode of the operation currently presented, feeding the compare stage.
   // ------------------------------------------------------------------------
   always_comb begin
      cur_rd   = 1'b0;
      cur_exp  = PATTERN;
      cur_elem = 3'd0;
      case (state)
         S_M0: cur_elem = 3'd0;
         S_M1: begin cur_elem = 3'd1; cur_rd = !phase; cur_exp = PATTERN;  end
         S_M2: begin cur_elem = 3'd2; cur_rd = !phase; cur_exp = ~PATTERN; end
         S_M3: begin cur_elem = 3'd3; cur_rd = !phase; cur_exp = PATTERN;  end
         S_M4: begin cur_elem = 3'd4; cur_rd = !phase; cur_exp = ~PATTERN; end
         S_M5: begin cur_elem = 3'd5; cur_rd = 1'b1;   cur_exp = PATTERN;  end
         default: cur_elem = 3'd0;
      endcase
   end

   // ------------------------------------------------------------------------
   // Macro command registers. Address and data hold when no op is issued.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sram_we    <= 1'b0;
         sram_wmask <= '0;
         sram_addr  <= '0;
         sram_din   <= '0;
      end else begin
         sram_we    <= op_we_nx;
         sram_wmask <= op_we_nx ? {WMASK_WIDTH{1'b1}} : {WMASK_WIDTH{1'b0}};
         if (op_active_nx) sram_addr <= addr_nx;
         if (op_we_nx)     sram_din  <= op_din_nx;
      end
   end

   // ------------------------------------------------------------------------
   // Compare pipeline and result registers. The compare in this cycle uses
   // the tag captured with the read, so an element change happening in the
   // same cycle does not disturb it.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmp_valid       <= 1'b0;
         cmp_addr        <= '0;
         cmp_elem        <= '0;
         cmp_exp         <= '0;
         err_count       <= '0;
         first_fail_addr <= '0;
         first_fail_elem <= '0;
      end else begin
         cmp_valid <= cur_rd;
         cmp_addr  <= addr;
         cmp_elem  <= cur_elem;
         cmp_exp   <= cur_exp;
         if (clear_nx) begin
            err_count       <= '0;
            first_fail_addr <= '0;
            first_fail_elem <= '0;
         end else if (cmp_valid && (sram_dout != cmp_exp)) begin
            // err_count only leaves zero through a mismatch, so zero marks
            // the first mismatch of the run.
            if (err_count == '0) begin
               first_fail_addr <= cmp_addr;
               first_fail_elem <= cmp_elem;
            end
            if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
         end
      end
   end

   assign busy = (state != S_IDLE) && (state != S_DONE);
   assign done = (state == S_DONE);
   assign pass = (state == S_DONE) && (err_count == '0);

endmodule

// File: tb/tb_sram_march_bist.sv
module tb_sram_march_bist;

  localparam logic [63:0] PAT = {32{2'b01}};

  typedef struct packed {
    logic        we;
    logic [7:0]  wmask;
    logic [8:0]  addr;
    logic [63:0] din;
  } op_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        start_b = 1'b0, start_s = 1'b0;
  logic        busy_b, done_b, pass_b, we_b;
  logic [7:0]  err_b, wmask_b;
  logic [8:0]  ffa_b, addr_b;
  logic [2:0]  ffe_b;
  logic [63:0] din_b, dout_b;

  logic        busy_s, done_s, pass_s, we_s;
  logic [3:0]  err_s;
  logic [7:0]  wmask_s;
  logic [1:0]  ffa_s, addr_s;
  logic [2:0]  ffe_s;
  logic [63:0] din_s, dout_s;

  sram_march_bist dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .first_fail_addr(ffa_b),
    .first_fail_elem(ffe_b), .sram_we(we_b), .sram_wmask(wmask_b),
    .sram_addr(addr_b), .sram_din(din_b), .sram_dout(dout_b)
  );

  sram_march_bist #(.ADDR_WIDTH(2), .ERR_CNT_WIDTH(4)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s),
    .pass(pass_s), .err_count(err_s), .first_fail_addr(ffa_s),
    .first_fail_elem(ffe_s), .sram_we(we_s), .sram_wmask(wmask_s),
    .sram_addr(addr_s), .sram_din(din_s), .sram_dout(dout_s)
  );

  // ---------------- fault settings and SRAM models ----------------
  int   fault_kind = 0;   // 0 none, 1 stuck bit at one address, 2 invert every read
  int   f_addr = 0;
  int   f_bit = 0;
  logic f_val = 1'b0;

  function automatic logic [63:0] faulty(input int a, input logic [63:0] v);
    logic [63:0] r;
    r = v;
    if (fault_kind == 1 && a == f_addr) r[f_bit] = f_val;
    if (fault_kind == 2) r = ~v;
    return r;
  endfunction

  logic [63:0] mem_b [512];
  logic [63:0] mem_s [4];

  always @(posedge clk) begin
    dout_b <= faulty(int'(addr_b), mem_b[addr_b]);
    if (we_b && wmask_b == 8'hFF) mem_b[addr_b] <= din_b;
    dout_s <= faulty(int'(addr_s), mem_s[addr_s]);
    if (we_s && wmask_s == 8'hFF) mem_s[addr_s] <= din_s;
  end

  // ---------------- observation mux ----------------
  logic        sel = 1'b0;   // 0: large instance, 1: small instance
  logic        o_busy, o_done, o_pass, o_we;
  logic [7:0]  o_err, o_wmask;
  logic [8:0]  o_ffa, o_addr;
  logic [2:0]  o_ffe;
  logic [63:0] o_din;

  assign o_busy  = sel ? busy_s : busy_b;
  assign o_done  = sel ? done_s : done_b;
  assign o_pass  = sel ? pass_s : pass_b;
  assign o_we    = sel ? we_s : we_b;
  assign o_err   = sel ? {4'b0, err_s} : err_b;
  assign o_wmask = sel ? wmask_s : wmask_b;
  assign o_ffa   = sel ? {7'b0, ffa_s} : ffa_b;
  assign o_addr  = sel ? {7'b0, addr_s} : addr_b;
  assign o_ffe   = sel ? ffe_s : ffe_b;
  assign o_din   = sel ? din_s : din_b;

  // ---------------- scoreboard ----------------
  int  tests = 0;
  int  fails = 0;
  op_t exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // March C- reference: walks the six elements as a list of (direction,
  // read background, write background), fills exp_q with the op trace and
  // derives the result registers from the fault model applied to each read.
  task automatic build_model(input int n, input int cnt_max,
                             output int errs, output int ffa, output int ffe);
    int up [6] = '{1, 1, 1, 0, 0, 0};
    int rd [6] = '{-1, 0, 1, 0, 1, 0};
    int wr [6] = '{0, 1, 0, 1, 0, -1};
    logic [63:0] last_din, e, got;
    op_t op;
    exp_q.delete();
    errs = 0; ffa = 0; ffe = 0;
    last_din = PAT;
    for (int el = 0; el < 6; el++) begin
      for (int k = 0; k < n; k++) begin
        int a;
        a = (up[el] != 0) ? k : n - 1 - k;
        if (rd[el] >= 0) begin
          e = (rd[el] == 1) ? ~PAT : PAT;
          op = '{we: 1'b0, wmask: 8'h00, addr: 9'(a), din: last_din};
          exp_q.push_back(op);
          got = faulty(a, e);
          if (got != e) begin
            if (errs == 0) begin ffa = a; ffe = el; end
            if (errs < cnt_max) errs++;
          end
        end
        if (wr[el] >= 0) begin
          last_din = (wr[el] == 1) ? ~PAT : PAT;
          op = '{we: 1'b1, wmask: 8'hFF, addr: 9'(a), din: last_din};
          exp_q.push_back(op);
        end
      end
    end
  endtask

  // One run on the selected instance: start pulse, cycle-by-cycle op check,
  // exact completion timing and results. repulse_at/abort_at are op indices
  // (-1 to skip) at which start is re-pulsed or rst is pulsed.
  task automatic run(input string tag, input int n, input int cnt_max,
                     input int repulse_at, input int abort_at);
    int errs, ffa, ffe;
    build_model(n, cnt_max, errs, ffa, ffe);
    @(negedge clk);
    if (sel) start_s = 1'b1; else start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0; start_s = 1'b0;
    for (int i = 0; i < 10 * n; i++) begin
      @(negedge clk);
      start_b = 1'b0; start_s = 1'b0;
      check($sformatf("%s op[%0d]", tag, i), 128'({o_we, o_wmask, o_addr, o_din}), 128'(exp_q[i]));
      if (i == 0)
        check({tag, " cleared_at_start"}, 128'({o_busy, o_done, o_pass, o_err, o_ffa, o_ffe}),
              128'({1'b1, 1'b0, 1'b0, 8'd0, 9'd0, 3'd0}));
      if (i == repulse_at) begin
        if (sel) start_s = 1'b1; else start_b = 1'b1;
      end
      if (i == abort_at) begin
        rst = 1'b1;
        #1;
        check({tag, " abort_immediate"},
              128'({o_busy, o_done, o_pass, o_err, o_ffa, o_ffe, o_we, o_wmask, o_addr, o_din}), 128'(0));
        @(posedge clk);
        #1;
        check({tag, " abort_next_cycle"},
              128'({o_busy, o_done, o_pass, o_err, o_ffa, o_ffe, o_we, o_wmask, o_addr, o_din}), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check({tag, " idle_after_abort"}, 128'({o_we, o_busy, o_done}), 128'(0));
        end
        return;
      end
    end
    @(negedge clk);
    check({tag, " busy_during_last_compare"}, 128'({o_busy, o_done}), 128'({1'b1, 1'b0}));
    @(negedge clk);
    check({tag, " done_flags"}, 128'({o_busy, o_done, o_pass}),
          128'({1'b0, 1'b1, (errs == 0) ? 1'b1 : 1'b0}));
    check({tag, " err_count"}, 128'(o_err), 128'(errs));
    check({tag, " first_fail"}, 128'({o_ffa, o_ffe}), 128'({9'(ffa), 3'(ffe)}));
    @(negedge clk);
    check({tag, " done_held"}, 128'({o_busy, o_done, o_we}), 128'({1'b0, 1'b1, 1'b0}));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("reset_big", 128'({busy_b, done_b, pass_b, err_b, ffa_b, ffe_b, we_b, wmask_b, addr_b, din_b}), 128'(0));
    check("reset_small", 128'({busy_s, done_s, pass_s, err_s, ffa_s, ffe_s, we_s, wmask_s, addr_s, din_s}), 128'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Small macro: exact trace, then every word corrupted with a 4-bit counter.
    sel = 1'b1;
    fault_kind = 0;
    run("small_clean", 4, 15, -1, -1);
    fault_kind = 2;
    run("small_corrupt", 4, 15, -1, -1);
    check("small_corrupt_explicit", 128'({err_s, ffa_s, ffe_s}), 128'({4'd15, 2'd0, 3'd1}));

    // Large macro: clean run with start re-pulsed while busy.
    sel = 1'b0;
    fault_kind = 0;
    run("big_clean_repulse", 512, 255, $urandom_range(1, 5119), -1);

    // Bit 17 stuck-at-0 at 0x1A3; started from DONE.
    fault_kind = 1; f_addr = 'h1A3; f_bit = 17; f_val = 1'b0;
    run("big_bit17", 512, 255, -1, -1);
    check("big_bit17_explicit", 128'({pass_b, err_b, ffa_b, ffe_b}), 128'({1'b0, 8'd2, 9'h1A3, 3'd2}));

    // Random stuck-at faults.
    for (int r = 0; r < 3; r++) begin
      fault_kind = 1;
      f_addr = $urandom_range(0, 511);
      f_bit = $urandom_range(0, 63);
      f_val = 1'($urandom_range(0, 1));
      run($sformatf("big_rand%0d", r), 512, 255, -1, -1);
    end

    // rst mid-M3, then a full clean run.
    fault_kind = 0;
    run("big_abort_m3", 512, 255, -1, 5 * 512 + $urandom_range(0, 2 * 512 - 1));
    run("big_after_abort", 512, 255, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
